// File: rtl/scroll_char_buffer.sv
// Character buffer for the terminal display with hardware scrolling (circular top-line offset),
// line clear on scroll and full-screen clear. Row/column addressing on both ports.
module scroll_char_buffer #(
    parameter int                   COLS      = 80,
    parameter int                   ROWS      = 25,
    parameter int                   DATA_BITS = 8,
    parameter int                   COL_BITS  = 7,
    parameter int                   ROW_BITS  = 5,
    parameter int                   ADDR_BITS = 11,
    parameter logic [DATA_BITS-1:0] FILL_CHAR = DATA_BITS'(8'h20)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] din,
    input  logic [ROW_BITS-1:0]  wrow,
    input  logic [COL_BITS-1:0]  wcol,
    input  logic                 write_en,
    input  logic [ROW_BITS-1:0]  rrow,
    input  logic [COL_BITS-1:0]  rcol,
    input  logic                 read_en,
    output logic [DATA_BITS-1:0] dout,
    input  logic                 scroll_up,
    input  logic                 clear_all,
    output logic                 busy,
    output logic [ROW_BITS-1:0]  top_line
);

    localparam int                   CELLS      = ROWS * COLS;
    localparam logic [ROW_BITS-1:0]  LAST_ROW   = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0]  LAST_COL   = COL_BITS'(COLS - 1);
    localparam logic [ADDR_BITS-1:0] LINE_END   = ADDR_BITS'(COLS - 1);
    localparam logic [ADDR_BITS-1:0] SCREEN_END = ADDR_BITS'(CELLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_ALL
    } state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   count;
    logic [ROW_BITS-1:0]    target_row;
    logic [DATA_BITS-1:0]   mem [CELLS];

    logic                   w_in_range;
    logic                   r_in_range;
    logic                   r_masked;
    logic [ADDR_BITS-1:0]   waddr_map;
    logic [ADDR_BITS-1:0]   raddr_map;
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [DATA_BITS-1:0]   mem_wdata;

    // Logical row -> physical row, rotated by the top-line offset with wrap at ROWS.
    function automatic logic [ROW_BITS-1:0] phys_row(input logic [ROW_BITS-1:0] row,
                                                     input logic [ROW_BITS-1:0] top);
        logic [ROW_BITS:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        if (sum > {1'b0, LAST_ROW}) begin
            sum = sum - (ROW_BITS + 1)'(ROWS);
        end
        return sum[ROW_BITS-1:0];
    endfunction

    function automatic logic [ADDR_BITS-1:0] cell_addr(input logic [ROW_BITS-1:0] prow,
                                                       input logic [COL_BITS-1:0] col);
        return ADDR_BITS'(prow) * ADDR_BITS'(COLS) + ADDR_BITS'(col);
    endfunction

    assign w_in_range = (wrow <= LAST_ROW) && (wcol <= LAST_COL);
    assign r_in_range = (rrow <= LAST_ROW) && (rcol <= LAST_COL);
    assign waddr_map  = cell_addr(phys_row(wrow, top_line), wcol);
    assign raddr_map  = cell_addr(phys_row(rrow, top_line), rcol);

    // The bottom logical row is the one being blanked during a line clear.
    assign r_masked = (state == CLR_ALL) || ((state == CLR_LINE) && (rrow == LAST_ROW));

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr_map;
        mem_wdata = din;
        case (state)
            IDLE: begin
                mem_we = write_en && !clear_all && w_in_range;
            end
            CLR_LINE: begin
                mem_we    = 1'b1;
                mem_waddr = cell_addr(target_row, COL_BITS'(count));
                mem_wdata = FILL_CHAR;
            end
            CLR_ALL: begin
                mem_we    = 1'b1;
                mem_waddr = count;
                mem_wdata = FILL_CHAR;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read sees pre-write contents when the same cell is written in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= FILL_CHAR;
        end else if (read_en) begin
            if (!r_in_range || r_masked) begin
                dout <= FILL_CHAR;
            end else begin
                dout <= mem[raddr_map];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLR_ALL;
            busy       <= 1'b1;
            count      <= '0;
            top_line   <= '0;
            target_row <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_all) begin
                        state    <= CLR_ALL;
                        busy     <= 1'b1;
                        count    <= '0;
                        top_line <= '0;
                    end else if (scroll_up) begin
                        state      <= CLR_LINE;
                        busy       <= 1'b1;
                        count      <= '0;
                        target_row <= top_line;
                        top_line   <= (top_line == LAST_ROW) ? '0 : top_line + 1'b1;
                    end
                end
                CLR_LINE: begin
                    count <= count + 1'b1;
                    if (count == LINE_END) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CLR_ALL: begin
                    count <= count + 1'b1;
                    if (count == SCREEN_END) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scroll_char_buffer.sv
// Directed bench for scroll_char_buffer: reset blanking, addressing, scrolling, line and screen clears.
module tb_scroll_char_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = '0;
    logic [4:0] wrow = '0;
    logic [6:0] wcol = '0;
    logic       write_en = 1'b0;
    logic [4:0] rrow = '0;
    logic [6:0] rcol = '0;
    logic       read_en = 1'b0;
    logic [7:0] dout;
    logic       scroll_up = 1'b0;
    logic       clear_all = 1'b0;
    logic       busy;
    logic [4:0] top_line;

    int errors = 0;
    int checks = 0;

    scroll_char_buffer dut (
        .clk(clk), .reset(reset), .din(din), .wrow(wrow), .wcol(wcol), .write_en(write_en),
        .rrow(rrow), .rcol(rcol), .read_en(read_en), .dout(dout),
        .scroll_up(scroll_up), .clear_all(clear_all), .busy(busy), .top_line(top_line)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input int c, input logic [7:0] d);
        wrow = 5'(r); wcol = 7'(c); din = d; write_en = 1'b1;
        tick();
        write_en = 1'b0;
    endtask

    task automatic rd(input int r, input int c, output logic [7:0] d);
        rrow = 5'(r); rcol = 7'(c); read_en = 1'b1;
        tick();
        read_en = 1'b0;
        d = dout;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            tick();
        end
    endtask

    task automatic pulse_scroll;
        scroll_up = 1'b1;
        tick();
        scroll_up = 1'b0;
    endtask

    task automatic blank_count(output int bad);
        logic [7:0] d;
        bad = 0;
        for (int r = 0; r < 25; r++) begin
            for (int c = 0; c < 80; c++) begin
                rd(r, c, d);
                if (d !== 8'h20) bad++;
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        int n;
        int bad;
        int exp_top;

        // reset and self-blanking
        repeat (3) tick();
        chk("reset_dout", dout, 8'h20);
        chk("reset_top", top_line, 0);
        chk("reset_busy", busy, 1);
        reset = 1'b0;
        wait_busy(n);
        chk("reset_busy_cycles", n, 2000);
        blank_count(bad);
        chk("reset_blank", bad, 0);
        chk("top_after_reset", top_line, 0);

        // basic addressing and out-of-range handling
        wr(0, 0, 8'h41);
        wr(24, 79, 8'h42);
        rd(0, 0, d);   chk("rd_0_0", d, 8'h41);
        tick();        chk("dout_hold", dout, 8'h41);
        rd(24, 79, d); chk("rd_24_79", d, 8'h42);
        wr(1, 0, 8'h43);
        wr(25, 0, 8'h55);
        wr(0, 80, 8'h66);
        rd(25, 0, d);  chk("rd_row_oor", d, 8'h20);
        rd(0, 80, d);  chk("rd_col_oor", d, 8'h20);
        rd(0, 0, d);   chk("oor_wr_row_dropped", d, 8'h41);
        rd(1, 0, d);   chk("oor_wr_col_dropped", d, 8'h43);

        // same-cell read and write returns old data
        wrow = 5'd2; wcol = 7'd2; din = 8'h77; write_en = 1'b1;
        rrow = 5'd2; rcol = 7'd2; read_en = 1'b1;
        tick();
        write_en = 1'b0; read_en = 1'b0;
        chk("rw_same_old", dout, 8'h20);
        rd(2, 2, d);   chk("rw_same_new", d, 8'h77);

        // fill row r with r, then scroll once
        for (int r = 0; r < 25; r++)
            for (int c = 0; c < 80; c++)
                wr(r, c, 8'(r));
        pulse_scroll();
        chk("scroll_top", top_line, 1);
        chk("scroll_busy", busy, 1);
        rd(24, 40, d); chk("scroll_mask_row24", d, 8'h20);
        rd(0, 0, d);   chk("scroll_unmasked_row0", d, 8'h01);
        wait_busy(n);
        chk("scroll_busy_cycles", n + 2, 80);
        rd(0, 10, d);  chk("after_scroll_row0", d, 8'h01);
        rd(23, 79, d); chk("after_scroll_row23", d, 8'h18);
        rd(24, 0, d);  chk("after_scroll_row24_c0", d, 8'h20);
        rd(24, 79, d); chk("after_scroll_row24_c79", d, 8'h20);

        // 25 scrolls: wraps back round to 1
        for (int i = 0; i < 25; i++) begin
            pulse_scroll();
            wait_busy(n);
            chk("loop_busy_cycles", n, 80);
            exp_top = (i + 2) % 25;
            chk("loop_top", top_line, exp_top);
            wr(3, 5, 8'(8'h60 + i));
            rd(3, 5, d);
            chk("loop_roundtrip", d, 8'h60 + i);
        end

        // write together with scroll uses old mapping; commands while busy are dropped
        wr(0, 0, 8'h5A);
        wrow = 5'd24; wcol = 7'd0; din = 8'h58; write_en = 1'b1; scroll_up = 1'b1;
        tick();
        write_en = 1'b0; scroll_up = 1'b0;
        chk("wr_scroll_top", top_line, 2);
        wrow = 5'd10; wcol = 7'd10; din = 8'h99; write_en = 1'b1; scroll_up = 1'b1;
        tick();
        write_en = 1'b0; scroll_up = 1'b0;
        wait_busy(n);
        chk("busy_drop_top", top_line, 2);
        rd(23, 0, d);  chk("wr_scroll_landed", d, 8'h58);
        rd(24, 0, d);  chk("old_top_cleared", d, 8'h20);
        rd(10, 10, d); chk("busy_write_dropped", d, 8'h20);

        // clear_all at top_line 7 interrupted by reset
        repeat (5) begin
            pulse_scroll();
            wait_busy(n);
        end
        chk("top_before_clear", top_line, 7);
        wr(0, 0, 8'hAA);
        rd(0, 0, d);   chk("pre_clear_rd", d, 8'hAA);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        chk("clear_top", top_line, 0);
        chk("clear_busy", busy, 1);
        repeat (998) tick();
        chk("clear_busy_mid", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_reset_dout", dout, 8'h20);
        wait_busy(n);
        chk("restart_busy_cycles", n, 2000);
        chk("restart_top", top_line, 0);
        blank_count(bad);
        chk("restart_blank", bad, 0);

        // uninterrupted clear_all length
        pulse_scroll();
        wait_busy(n);
        chk("pre_clear2_top", top_line, 1);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        wait_busy(n);
        chk("clear_busy_cycles", n, 2000);
        chk("clear2_top", top_line, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scroll_char_buffer.md
# scroll_char_buffer

Parametrised character buffer for the terminal display, built as the successor to the fixed 80x25 buffer. It adds hardware scrolling through a circular top-line offset, a line-clear engine that blanks the new bottom line on scroll, and a full-screen clear. Row/column addressing replaces flat addresses on both ports. It sits between the terminal command logic (write port) and the video character generator (read port).

## Interface
- COLS, 80, characters per line
- ROWS, 25, lines per screen
- DATA_BITS, 8, bits per character cell
- COL_BITS, 7, width of column indices
- ROW_BITS, 5, width of row indices
- ADDR_BITS, 11, physical RAM address width (must hold ROWS*COLS-1)
- FILL_CHAR, 8'h20, value written by clears and returned for masked reads (DATA_BITS wide)

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- din  in  DATA_BITS  write data
- wrow  in  ROW_BITS  logical write row
- wcol  in  COL_BITS  write column
- write_en  in  1  write strobe
- rrow  in  ROW_BITS  logical read row
- rcol  in  COL_BITS  read column
- read_en  in  1  read strobe
- dout  out  DATA_BITS  registered read data
- scroll_up  in  1  one-cycle pulse: scroll screen up one line
- clear_all  in  1  one-cycle pulse: blank entire screen, home offset
- busy  out  1  clear engine active; commands and writes dropped
- top_line  out  ROW_BITS  current physical row shown as logical row 0

## Operation
- Storage: ROWS*COLS x DATA_BITS simple dual-port RAM, one write port, one read port; contents not reset.
- Mapping: phys = row + top_line; if phys >= ROWS, subtract ROWS; addr = phys*COLS + col. Same mapping on both ports, using top_line value of the current cycle.
- Out of range (row >= ROWS or col >= COLS): write dropped; read returns FILL_CHAR.
- FSM states: IDLE, CLR_LINE, CLR_ALL.
- IDLE, priority clear_all > scroll_up > write_en:
  - clear_all: enter CLR_ALL, top_line <= 0, counter <= 0.
  - scroll_up: if write_en also high, the write completes this cycle with the old mapping. Line-clear target = old top_line physical row. top_line <= (top_line+1) wrap at ROWS. Enter CLR_LINE, counter <= 0.
  - write_en alone: write din to mapped address.
- CLR_LINE: write FILL_CHAR to target_row*COLS + counter; counter increments. After counter == COLS-1 is written, return to IDLE.
- CLR_ALL: write FILL_CHAR to address counter, 0..ROWS*COLS-1, then return to IDLE.
- While busy: write_en, scroll_up and clear_all are ignored (dropped, not queued). Reads are always serviced.
- Read masking while busy: in CLR_LINE, reads of logical row ROWS-1 return FILL_CHAR. In CLR_ALL, all reads return FILL_CHAR. All other reads return RAM contents.
- Reset: top_line = 0; dout = FILL_CHAR; the FSM enters CLR_ALL, so the screen self-blanks after reset. Reset asserted mid-clear restarts CLR_ALL from address 0.

## Timing
- Read latency 1: read_en sampled at edge t, dout valid after edge t; dout holds its value when read_en = 0.
- Read and write to the same cell in the same cycle: dout returns old data.
- scroll_up accepted at edge t: top_line new from t+1. busy = 1 for cycles t+1..t+COLS (COLS clear writes). busy = 0 and commands accepted from t+COLS+1.
- clear_all accepted at edge t: busy = 1 for ROWS*COLS cycles.
- After reset deasserts at edge t: busy = 1 through t+ROWS*COLS, then 0.
- busy is a registered output, derived from FSM state != IDLE.

## Test plan
- Reset, then wait: busy is high for 2000 cycles after reset release. Then read every cell: all return 8'h20, and top_line = 0.
- Write 8'h41 at (0,0) and 8'h42 at (24,79); read both back: dout = 8'h41 and 8'h42, one cycle after read_en. Write to (25,0) and (0,80): dropped. Reads there return 8'h20.
- Fill row r with value r (r = 0..24), then pulse scroll_up: top_line = 1. During the 80 busy cycles, reading row 24 returns 8'h20. Afterward, logical row 0 reads 1, logical row 23 reads 24, logical row 24 reads 8'h20.
- Pulse scroll_up 25 times, waiting out busy each time: top_line wraps from 24 to 0. A write/read at (3,5) still round-trips correctly after every scroll.
- Assert write_en (row 24, 8'h58) together with scroll_up: the write lands in old row 24, which reads back as 8'h58 at logical row 23. Pulse write_en and scroll_up while busy: both dropped, and top_line is unchanged.
- Pulse clear_all with top_line = 7: top_line becomes 0 the next cycle and busy is high for 2000 cycles. Assert reset at cycle 1000: the clear restarts and busy stays high for 2000 cycles from reset release. Afterward, every cell reads 8'h20.
